// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority arbiter.
package rr_arbiter_pkg;

    // Index width for an N-entry vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: reports the highest-priority set bit
// as an index and as a one-hot vector.
module priority_encoder
    import rr_arbiter_pkg::*;
#(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic [WIDTH-1:0]            input_unencoded,
    output logic                        output_valid,
    output logic [idx_width(WIDTH)-1:0] output_encoded,
    output logic [WIDTH-1:0]            output_unencoded
);

    localparam int IDX_W = idx_width(WIDTH);

    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
        output_valid   = 1'b0;
        output_encoded = '0;
        if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (input_unencoded[i]) begin
                    output_valid   = 1'b1;
                    output_encoded = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (input_unencoded[i]) begin
                    output_valid   = 1'b1;
                    output_encoded = IDX_W'(i);
                end
            end
        end
    end

    assign output_unencoded = output_valid ? (WIDTH'(1) << output_encoded) : '0;

endmodule

// File: rtl/rr_arbiter.sv
// Registered N-way request arbiter with fixed-priority or round-robin
// selection and per-cycle / hold-while-requesting / hold-until-ack modes.
// Optional macro RR_ARBITER_TIMEOUT_EN adds a hold-timeout that forcibly
// releases a block-mode grant after TIMEOUT_CYCLES cycles.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int PORTS                = 4,
    parameter int ARB_TYPE_ROUND_ROBIN = 1,
    parameter int ARB_BLOCK            = 1,
    parameter int ARB_BLOCK_ACK        = 1,
    parameter int LSB_HIGH_PRIORITY    = 0
`ifdef RR_ARBITER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES       = 256
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            request,
    input  logic [PORTS-1:0]            acknowledge,
    output logic [PORTS-1:0]            grant,
    output logic                        grant_valid,
    output logic [idx_width(PORTS)-1:0] grant_encoded
`ifdef RR_ARBITER_TIMEOUT_EN
    ,
    output logic                        grant_timeout
`endif
);

    localparam int               IDX_W    = idx_width(PORTS);
    localparam logic [PORTS-1:0] ALL_ONES = '1;

    arb_state_e       state_p1, state_nxt;
    logic [PORTS-1:0] grant_p1, grant_nxt;
    logic [PORTS-1:0] mask_p1, mask_nxt;
    logic [IDX_W-1:0] idx_p1, idx_nxt;

    logic [PORTS-1:0] masked_req;
    logic             m_valid, u_valid;
    logic [IDX_W-1:0] m_idx, u_idx;
    logic [PORTS-1:0] m_onehot, u_onehot;
    logic [PORTS-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;

    logic             normal_release;
    logic             timeout_hit;
    logic             release_now;
    logic             new_grant;

    assign masked_req = request & mask_p1;

    priority_encoder #(
        .WIDTH            (PORTS),
        .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)
    ) u_pe_masked (
        .input_unencoded (masked_req),
        .output_valid    (m_valid),
        .output_encoded  (m_idx),
        .output_unencoded(m_onehot)
    );

    priority_encoder #(
        .WIDTH            (PORTS),
        .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)
    ) u_pe_unmasked (
        .input_unencoded (request),
        .output_valid    (u_valid),
        .output_encoded  (u_idx),
        .output_unencoded(u_onehot)
    );

    // Masked winner first; an empty masked set wraps to the unmasked winner.
    assign pick_onehot = m_valid ? m_onehot : u_onehot;
    assign pick_idx    = m_valid ? m_idx    : u_idx;

    // Release condition for the currently held grant, by hold mode.
    always_comb begin
        normal_release = 1'b1;
        if (ARB_BLOCK != 0) begin
            normal_release = (ARB_BLOCK_ACK != 0) ? acknowledge[idx_p1] : ~request[idx_p1];
        end
    end

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam int CNT_W = idx_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] hold_cnt_p1;
    logic             timeout_p1;

    assign timeout_hit = (ARB_BLOCK != 0) && (state_p1 == GRANTED) &&
                         (hold_cnt_p1 == CNT_W'(TIMEOUT_CYCLES - 1));

    // Hold counter restarts on each new grant; pulse flags a forced release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_p1 <= '0;
            timeout_p1  <= 1'b0;
        end else begin
            timeout_p1 <= timeout_hit && !normal_release;
            if (new_grant || state_nxt == IDLE) begin
                hold_cnt_p1 <= '0;
            end else begin
                hold_cnt_p1 <= hold_cnt_p1 + 1'b1;
            end
        end
    end

    assign grant_timeout = timeout_p1;
`else
    assign timeout_hit = 1'b0;
`endif

    assign release_now = (state_p1 == GRANTED) && (normal_release || timeout_hit);

    // Next state: arbitrate when idle or releasing, otherwise hold the grant.
    always_comb begin
        state_nxt = state_p1;
        grant_nxt = grant_p1;
        idx_nxt   = idx_p1;
        mask_nxt  = mask_p1;
        new_grant = 1'b0;
        if (state_p1 == IDLE || release_now) begin
            if (|request) begin
                state_nxt = GRANTED;
                grant_nxt = pick_onehot;
                idx_nxt   = pick_idx;
                new_grant = 1'b1;
                if (ARB_TYPE_ROUND_ROBIN != 0) begin
                    mask_nxt = (LSB_HIGH_PRIORITY != 0) ? ((ALL_ONES << pick_idx) << 1)
                                                        : ~(ALL_ONES << pick_idx);
                end
            end else begin
                state_nxt = IDLE;
                grant_nxt = '0;
                idx_nxt   = '0;
            end
        end
    end

    // State, grant and rotation mask registers; reset clears immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1 <= IDLE;
            grant_p1 <= '0;
            idx_p1   <= '0;
            mask_p1  <= ALL_ONES;
        end else begin
            state_p1 <= state_nxt;
            grant_p1 <= grant_nxt;
            idx_p1   <= idx_nxt;
            mask_p1  <= mask_nxt;
        end
    end

    assign grant         = grant_p1;
    assign grant_valid   = |grant_p1;
    assign grant_encoded = idx_p1;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench: five arbiter configurations run side by side against
// a rotating-search reference model, with directed literal checks.
module tb_rr_arbiter;

    localparam int NC = 5;
    localparam int NP   [NC] = '{4, 4, 4, 4, 5};
    localparam int RRC  [NC] = '{1, 0, 1, 1, 1};
    localparam int BLKC [NC] = '{0, 0, 1, 1, 1};
    localparam int ACKC [NC] = '{1, 1, 1, 0, 0};
    localparam int LSBC [NC] = '{1, 0, 1, 1, 0};
    localparam int TOC  [NC] = '{256, 256, 8, 256, 256};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] req [NC];
    logic [4:0] ack [NC];

    logic [3:0] gnt0, gnt1, gnt2, gnt3;
    logic [4:0] gnt4;
    logic       vld0, vld1, vld2, vld3, vld4;
    logic [1:0] enc0, enc1, enc2, enc3;
    logic [2:0] enc4;
    logic [4:0] to_w;

    logic [4:0] act_g [NC];
    logic       act_v [NC];
    logic [2:0] act_e [NC];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // model state
    bit held_m [NC];
    int g_m    [NC];
    int last_m [NC];
    int cnt_m  [NC];
    bit to_m   [NC];

    always #5 clk = ~clk;

`ifdef RR_ARBITER_TIMEOUT_EN
    `define TOPORT(n) , .grant_timeout(to_w[n])
    `define TOPAR(t) , .TIMEOUT_CYCLES(t)
`else
    `define TOPORT(n)
    `define TOPAR(t)
    assign to_w = '0;
`endif

    rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1),
                 .LSB_HIGH_PRIORITY(1) `TOPAR(256)) dut0 (
        .clk(clk), .rst(rst), .request(req[0][3:0]), .acknowledge(ack[0][3:0]),
        .grant(gnt0), .grant_valid(vld0), .grant_encoded(enc0) `TOPORT(0));
    rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1),
                 .LSB_HIGH_PRIORITY(0) `TOPAR(256)) dut1 (
        .clk(clk), .rst(rst), .request(req[1][3:0]), .acknowledge(ack[1][3:0]),
        .grant(gnt1), .grant_valid(vld1), .grant_encoded(enc1) `TOPORT(1));
    rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
                 .LSB_HIGH_PRIORITY(1) `TOPAR(8)) dut2 (
        .clk(clk), .rst(rst), .request(req[2][3:0]), .acknowledge(ack[2][3:0]),
        .grant(gnt2), .grant_valid(vld2), .grant_encoded(enc2) `TOPORT(2));
    rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
                 .LSB_HIGH_PRIORITY(1) `TOPAR(256)) dut3 (
        .clk(clk), .rst(rst), .request(req[3][3:0]), .acknowledge(ack[3][3:0]),
        .grant(gnt3), .grant_valid(vld3), .grant_encoded(enc3) `TOPORT(3));
    rr_arbiter #(.PORTS(5), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
                 .LSB_HIGH_PRIORITY(0) `TOPAR(256)) dut4 (
        .clk(clk), .rst(rst), .request(req[4]), .acknowledge(ack[4]),
        .grant(gnt4), .grant_valid(vld4), .grant_encoded(enc4) `TOPORT(4));

    always_comb begin
        act_g[0] = {1'b0, gnt0}; act_v[0] = vld0; act_e[0] = {1'b0, enc0};
        act_g[1] = {1'b0, gnt1}; act_v[1] = vld1; act_e[1] = {1'b0, enc1};
        act_g[2] = {1'b0, gnt2}; act_v[2] = vld2; act_e[2] = {1'b0, enc2};
        act_g[3] = {1'b0, gnt3}; act_v[3] = vld3; act_e[3] = {1'b0, enc3};
        act_g[4] = gnt4;         act_v[4] = vld4; act_e[4] = enc4;
    end

    function automatic bit bit_of(input logic [4:0] v, input int i);
        return ((v >> i) & 5'd1) != 5'd0;
    endfunction

    // Winner by rotating search: start just past the last grant in priority
    // order (or at the top-priority end after reset), first requester wins.
    function automatic int pick(input int c, input logic [4:0] r);
        int n, start, idx;
        n = NP[c];
        if (RRC[c] == 0 || last_m[c] < 0) start = (LSBC[c] != 0) ? 0 : n - 1;
        else start = (LSBC[c] != 0) ? (last_m[c] + 1) % n : (last_m[c] - 1 + n) % n;
        for (int k = 0; k < n; k++) begin
            idx = (LSBC[c] != 0) ? (start + k) % n : (start - k + n) % n;
            if (bit_of(r, idx)) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            held_m[c] = 0; g_m[c] = 0; last_m[c] = -1; cnt_m[c] = 0; to_m[c] = 0;
        end
    endtask

    task automatic model_step();
        bit rel, norm;
        int p;
        for (int c = 0; c < NC; c++) begin
            to_m[c] = 0;
            rel = 0;
            if (held_m[c]) begin
                if (BLKC[c] == 0) norm = 1;
                else if (ACKC[c] != 0) norm = bit_of(ack[c], g_m[c]);
                else norm = !bit_of(req[c], g_m[c]);
                rel = norm;
`ifdef RR_ARBITER_TIMEOUT_EN
                if (BLKC[c] != 0 && !norm && cnt_m[c] == TOC[c] - 1) begin
                    rel = 1; to_m[c] = 1;
                end
`endif
                if (!rel) cnt_m[c]++;
            end
            if (!held_m[c] || rel) begin
                p = pick(c, req[c]);
                cnt_m[c] = 0;
                if (p >= 0) begin
                    held_m[c] = 1; g_m[c] = p; last_m[c] = p;
                end else begin
                    held_m[c] = 0;
                end
            end
        end
    endtask

    // Compare every configuration against the model.
    task automatic check_all();
        logic [4:0] eg;
        logic [2:0] ee;
        for (int c = 0; c < NC; c++) begin
            eg = held_m[c] ? (5'd1 << g_m[c]) : 5'd0;
            ee = held_m[c] ? 3'(g_m[c]) : 3'd0;
            vectors++;
            if (act_g[c] !== eg || act_v[c] !== held_m[c] || act_e[c] !== ee
`ifdef RR_ARBITER_TIMEOUT_EN
                || to_w[c] !== to_m[c]
`endif
               ) begin
                miscompares++;
                $display("FAIL model dut%0d cycle %0d: got grant=%b valid=%b enc=%0d to=%b, want grant=%b valid=%b enc=%0d to=%b",
                         c, cyc, act_g[c], act_v[c], act_e[c], to_w[c], eg, held_m[c], ee, to_m[c]);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        cyc++;
        @(negedge clk);
        check_all();
        #1;
    endtask

    task automatic clear_inputs();
        for (int c = 0; c < NC; c++) begin
            req[c] = '0; ack[c] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        cycle();
        rst = 1'b0;
    endtask

    logic [4:0] exp_seq [5];

    initial begin
        clear_inputs();
        model_reset();
        #2;
        do_reset();
        chk("reset_grant", {27'd0, gnt4}, 32'd0);
        chk("reset_valid", {31'd0, vld0}, 32'd0);

        // Round-robin fairness, per-cycle mode.
        req[0] = 5'b01111;
        exp_seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b00001};
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_grant", {28'd0, gnt0}, {27'd0, exp_seq[i]});
            chk("rr_enc", {30'd0, enc0}, i % 4);
        end
        clear_inputs();
        do_reset();

        // Fixed priority, MSB highest.
        req[1] = 5'b00101;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("fixed_grant", {28'd0, gnt1}, 32'h4);
            chk("fixed_enc", {30'd0, enc1}, 32'd2);
        end
        clear_inputs();
        do_reset();

        // Hold until acknowledged.
        req[2] = 5'b00011;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("ack_hold", {28'd0, gnt2}, 32'h1);
        end
        ack[2] = 5'b00010;
        cycle();
        chk("ack_other_ignored", {28'd0, gnt2}, 32'h1);
        ack[2] = 5'b00001;
        cycle();
        ack[2] = '0;
        chk("ack_release", {28'd0, gnt2}, 32'h2);
        clear_inputs();
        do_reset();

        // Hold while requesting, release on drop.
        req[3] = 5'b00001;
        cycle();
        cycle();
        chk("drop_hold", {28'd0, gnt3}, 32'h1);
        req[3] = 5'b01000;
        cycle();
        chk("drop_next", {28'd0, gnt3}, 32'h8);
        req[3] = 5'b00000;
        cycle();
        chk("drop_idle_valid", {31'd0, vld3}, 32'd0);
        clear_inputs();
        do_reset();

        // Asynchronous reset in the middle of a held grant.
        req[2] = 5'b00100;
        cycle(); cycle(); cycle();
        chk("pre_reset_grant", {28'd0, gnt2}, 32'h4);
        rst = 1'b1;
        #1;
        chk("async_reset_grant", {28'd0, gnt2}, 32'h0);
        chk("async_reset_valid", {31'd0, vld2}, 32'd0);
        model_reset();
        cycle();
        rst = 1'b0;
        cycle();
        chk("post_reset_grant", {28'd0, gnt2}, 32'h4);
        clear_inputs();
        do_reset();

`ifdef RR_ARBITER_TIMEOUT_EN
        // Ack never arrives: forced release after the hold limit.
        req[2] = 5'b00011;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("to_hold", {28'd0, gnt2}, 32'h1);
            chk("to_quiet", {31'd0, to_w[2]}, 32'd0);
        end
        cycle();
        chk("to_next", {28'd0, gnt2}, 32'h2);
        chk("to_pulse", {31'd0, to_w[2]}, 32'd1);
        cycle();
        chk("to_pulse_end", {31'd0, to_w[2]}, 32'd0);
        clear_inputs();
        do_reset();
`endif

        // Randomised traffic on all configurations.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NC; c++) begin
                req[c] = 5'($urandom_range(0, (1 << NP[c]) - 1));
                if ($urandom_range(0, 3) == 0) req[c] = '0;
                ack[c] = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, (1 << NP[c]) - 1)) : 5'd0;
            end
            rst = ($urandom_range(0, 199) == 0);
            if (rst) model_reset();
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
